// File: rtl/eda_regional_max_core_if.sv
// Bus bundle for the regional-max window engine: pixel writes,
// window requests, flag readback and completion status.
interface eda_regional_max_core_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int PIXEL_WIDTH = 8
);
   logic                   write_en;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [PIXEL_WIDTH-1:0] pixel_in;
   logic [ADDR_WIDTH-1:0]  center_addr;
   logic                   new_pixel;
   logic                   clear;
   logic [ADDR_WIDTH-1:0]  flag_addr;
   logic                   flag_out;
   logic                   busy;
   logic                   done;
   logic                   changed;

   modport master (
      output write_en, wr_addr, pixel_in,
      output center_addr, new_pixel, clear, flag_addr,
      input  flag_out, busy, done, changed
   );

   modport slave (
      input  write_en, wr_addr, pixel_in,
      input  center_addr, new_pixel, clear, flag_addr,
      output flag_out, busy, done, changed
   );
endinterface

// File: rtl/eda_regional_max_core.sv
// Regional-maximum window engine: one 3x3 window per request, 11 cycles.
// EDA_REGIONAL_MAX_CONN8_EN selects 8-connectivity (default 4-connectivity).
module eda_regional_max_core #(
  parameter int M            = 6,
  parameter int N            = 6,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int I_WIDTH      = $clog2(M),
  parameter int J_WIDTH      = $clog2(N),
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  eda_regional_max_core_if.slave bus
);

   localparam int CW = $clog2(WINDOW_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WINDOW_WIDTH - 1);
   localparam logic [I_WIDTH:0] MROWS = (I_WIDTH + 1)'(M);
   localparam logic [J_WIDTH:0] NCOLS = (J_WIDTH + 1)'(N);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      UPDATE
   } state_e;

   state_e                 state_q;
   logic [I_WIDTH-1:0]     ci_q;
   logic [J_WIDTH-1:0]     cj_q;
   logic [CW-1:0]          cnt_q;
   logic                   kill_q;
   logic                   kill_d;
   logic                   busy_q;
   logic                   done_q;
   logic                   changed_q;

   logic [PIXEL_WIDTH-1:0] pix_q [M][N];
   logic                   flg_q [M][N];

   logic [I_WIDTH-1:0]     wr_i;
   logic [J_WIDTH-1:0]     wr_j;
   logic                   wr_ok;
   logic [I_WIDTH-1:0]     ca_i;
   logic [J_WIDTH-1:0]     ca_j;
   logic                   ca_ok;
   logic [I_WIDTH-1:0]     fl_i;
   logic [J_WIDTH-1:0]     fl_j;
   logic                   fl_ok;

   assign wr_i  = bus.wr_addr[ADDR_WIDTH-1:J_WIDTH];
   assign wr_j  = bus.wr_addr[J_WIDTH-1:0];
   assign wr_ok = bus.write_en && !busy_q
                  && ({1'b0, wr_i} < MROWS)
                  && ({1'b0, wr_j} < NCOLS);

   assign ca_i  = bus.center_addr[ADDR_WIDTH-1:J_WIDTH];
   assign ca_j  = bus.center_addr[J_WIDTH-1:0];
   assign ca_ok = ({1'b0, ca_i} < MROWS)
                  && ({1'b0, ca_j} < NCOLS);

   assign fl_i  = bus.flag_addr[ADDR_WIDTH-1:J_WIDTH];
   assign fl_j  = bus.flag_addr[J_WIDTH-1:0];
   assign fl_ok = ({1'b0, fl_i} < MROWS)
                  && ({1'b0, fl_j} < NCOLS);

   assign bus.flag_out = fl_ok ? flg_q[fl_i][fl_j] : 1'b0;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.changed  = changed_q;

   // Window offset as (dr, dc) in 0..2, i.e. offset + 1.
   logic [1:0]   dr;
   logic [1:0]   dc;
   logic [3:0]   idx;

   assign idx = 4'(cnt_q);

   always_comb begin
      dr = 2'd1;
      dc = 2'd1;
      unique case (idx)
         4'd0:    begin dr = 2'd0; dc = 2'd0; end
         4'd1:    begin dr = 2'd0; dc = 2'd1; end
         4'd2:    begin dr = 2'd0; dc = 2'd2; end
         4'd3:    begin dr = 2'd1; dc = 2'd0; end
         4'd4:    begin dr = 2'd1; dc = 2'd1; end
         4'd5:    begin dr = 2'd1; dc = 2'd2; end
         4'd6:    begin dr = 2'd2; dc = 2'd0; end
         4'd7:    begin dr = 2'd2; dc = 2'd1; end
         4'd8:    begin dr = 2'd2; dc = 2'd2; end
         default: begin dr = 2'd1; dc = 2'd1; end
      endcase
   end

   logic [I_WIDTH:0]       sr;
   logic [J_WIDTH:0]       sc;
   logic [I_WIDTH-1:0]     nr;
   logic [J_WIDTH-1:0]     nc;
   logic                   row_ok;
   logic                   col_ok;
   logic                   is_ctr;
   logic                   is_diag;
   logic                   nb_valid;
   logic [PIXEL_WIDTH-1:0] pc;
   logic [PIXEL_WIDTH-1:0] pq;
   logic                   fq;
   logic                   kill_now;

   // sr/sc are the neighbour coordinate plus one, so -1 maps to 0.
   assign sr     = {1'b0, ci_q} + (I_WIDTH + 1)'(dr);
   assign sc     = {1'b0, cj_q} + (J_WIDTH + 1)'(dc);
   assign row_ok = (sr != '0) && (sr <= MROWS);
   assign col_ok = (sc != '0) && (sc <= NCOLS);
   assign nr     = sr[I_WIDTH-1:0] - I_WIDTH'(1);
   assign nc     = sc[J_WIDTH-1:0] - J_WIDTH'(1);

   assign is_ctr  = (dr == 2'd1) && (dc == 2'd1);
   assign is_diag = (dr != 2'd1) && (dc != 2'd1);

`ifdef EDA_REGIONAL_MAX_CONN8_EN
   assign nb_valid = row_ok && col_ok && !is_ctr;
`else
   assign nb_valid = row_ok && col_ok && !is_ctr && !is_diag;
`endif

   assign pc = pix_q[ci_q][cj_q];
   assign pq = nb_valid ? pix_q[nr][nc] : '0;
   assign fq = nb_valid ? flg_q[nr][nc] : 1'b1;

   assign kill_now = nb_valid
                     && ((pq > pc) || ((pq == pc) && !fq));
   assign kill_d   = kill_q | kill_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
               pix_q[r][c] <= '0;
      end else if (wr_ok) begin
         pix_q[wr_i][wr_j] <= bus.pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ci_q      <= '0;
         cj_q      <= '0;
         cnt_q     <= '0;
         kill_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         changed_q <= 1'b0;
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
               flg_q[r][c] <= 1'b1;
      end else begin
         done_q    <= 1'b0;
         changed_q <= 1'b0;
         if (bus.clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < M; r++)
               for (int c = 0; c < N; c++)
                  flg_q[r][c] <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (bus.new_pixel && ca_ok) begin
                     ci_q    <= ca_i;
                     cj_q    <= ca_j;
                     cnt_q   <= '0;
                     kill_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= FETCH;
                  end
               end
               FETCH: begin
                  kill_q <= kill_d;
                  cnt_q  <= cnt_q + CW'(1);
                  if (cnt_q == LAST)
                     state_q <= UPDATE;
               end
               UPDATE: begin
                  if (kill_q && flg_q[ci_q][cj_q]) begin
                     flg_q[ci_q][cj_q] <= 1'b0;
                     changed_q         <= 1'b1;
                  end
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eda_regional_max_core.sv
// Directed bench for eda_regional_max_core with a reference model
// and a scoreboard of expected 'changed' results.
module tb_eda_regional_max_core;

   logic clk;
   logic reset;

   eda_regional_max_core_if #(.ADDR_WIDTH(6), .PIXEL_WIDTH(8)) bus ();

   eda_regional_max_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int miss = 0;
   int mpix [6][6];
   bit mflg [6][6];
   bit sb [$];

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_req(input int i, input int j);
      bit k;
      k = 1'b0;
      for (int di = -1; di <= 1; di++) begin
         for (int dj = -1; dj <= 1; dj++) begin
            int r;
            int c;
            bit use_it;
            r = i + di;
            c = j + dj;
            use_it = !(di == 0 && dj == 0)
                     && r >= 0 && r < 6 && c >= 0 && c < 6;
`ifndef EDA_REGIONAL_MAX_CONN8_EN
            if (di != 0 && dj != 0) use_it = 1'b0;
`endif
            if (use_it) begin
               if (mpix[r][c] > mpix[i][j]) k = 1'b1;
               if (mpix[r][c] == mpix[i][j] && !mflg[r][c]) k = 1'b1;
            end
         end
      end
      model_req = k && mflg[i][j];
      if (model_req) mflg[i][j] = 1'b0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            mpix[r][c] = 0;
            mflg[r][c] = 1'b1;
         end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            mflg[r][c] = 1'b1;
   endtask

   task automatic wr(input int i, input int j, input int v);
      bus.write_en = 1'b1;
      bus.wr_addr  = {3'(i), 3'(j)};
      bus.pixel_in = 8'(v);
      @(negedge clk);
      bus.write_en = 1'b0;
      if (i < 6 && j < 6) mpix[i][j] = v;
   endtask

   task automatic fill(input int v);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            wr(r, c, v);
   endtask

   task automatic clr();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      model_clear();
   endtask

   task automatic chk_flag(input string tag, input int i, input int j,
                           input bit exp);
      bus.flag_addr = {3'(i), 3'(j)};
      #1;
      check(tag, 32'(bus.flag_out), 32'(exp));
      check({tag, "_model"}, 32'(bus.flag_out), 32'(mflg[i][j]));
   endtask

   // Issue one request; optionally inject a second new_pixel or a
   // pixel write while busy. done must arrive at the 11th negedge.
   task automatic run_req(input int i, input int j,
                          input bit inject, input bit wr_busy);
      int lat;
      bit got;
      bit exp_c;
      sb.push_back(model_req(i, j));
      bus.center_addr = {3'(i), 3'(j)};
      bus.new_pixel   = 1'b1;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 30) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.new_pixel = 1'b0;
            check("busy_rise", 32'(bus.busy), 32'd1);
         end
         if (lat == 2 && wr_busy) begin
            bus.write_en = 1'b1;
            bus.wr_addr  = {3'd2, 3'd3};
            bus.pixel_in = 8'd9;
         end
         if (lat == 3) begin
            bus.write_en = 1'b0;
            if (inject) begin
               bus.center_addr = {3'd2, 3'd2};
               bus.new_pixel   = 1'b1;
            end
         end
         if (lat == 4) bus.new_pixel = 1'b0;
         if (lat == 10) check("busy_k9", 32'(bus.busy), 32'd1);
         if (bus.done) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
      exp_c = sb.pop_front();
      if (got) begin
         check("latency", 32'(lat), 32'd11);
         check("changed", 32'(bus.changed), 32'(exp_c));
         check("busy_fall", 32'(bus.busy), 32'd0);
         @(negedge clk);
         check("done_pulse", 32'(bus.done), 32'd0);
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
   endtask

   int nd;

   initial begin
      bus.write_en    = 1'b0;
      bus.wr_addr     = '0;
      bus.pixel_in    = '0;
      bus.center_addr = '0;
      bus.new_pixel   = 1'b0;
      bus.clear       = 1'b0;
      bus.flag_addr   = '0;
      reset           = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_changed", 32'(bus.changed), 32'd0);
      chk_flag("rst_flag00", 0, 0, 1'b1);
      chk_flag("rst_flag55", 5, 5, 1'b1);

      // Flat image: nothing killed
      fill(5);
      run_req(0, 0, 1'b0, 1'b0);
      chk_flag("flat_flag00", 0, 0, 1'b1);

      // Strictly greater neighbour kills
      wr(0, 1, 9);
      run_req(0, 0, 1'b0, 1'b0);
      chk_flag("gt_flag00", 0, 0, 1'b0);
      run_req(0, 1, 1'b0, 1'b0);
      chk_flag("gt_flag01", 0, 1, 1'b1);

      // Propagation through an equal, already-cleared neighbour
      wr(0, 1, 4);
      wr(1, 1, 4);
      wr(2, 0, 4);
      wr(2, 1, 4);
      run_req(1, 0, 1'b0, 1'b0);
      chk_flag("prop_flag10", 1, 0, 1'b0);
      run_req(1, 0, 1'b0, 1'b0);
      chk_flag("sticky_flag10", 1, 0, 1'b0);

      // Diagonal-only larger neighbour
      clr();
      fill(5);
      wr(1, 1, 9);
      run_req(0, 0, 1'b0, 1'b0);
`ifdef EDA_REGIONAL_MAX_CONN8_EN
      chk_flag("diag_flag00", 0, 0, 1'b0);
`else
      chk_flag("diag_flag00", 0, 0, 1'b1);
`endif

      // Corner (5,5) with larger left neighbour
      wr(5, 4, 7);
      run_req(5, 5, 1'b0, 1'b0);
      chk_flag("corner_flag55", 5, 5, 1'b0);

      // Clear at k+4 aborts a killing request
      clr();
      fill(5);
      wr(0, 1, 9);
      bus.center_addr = {3'd0, 3'd0};
      bus.new_pixel   = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         if (t == 1) bus.new_pixel = 1'b0;
         if (t == 4) bus.clear = 1'b1;
      end
      bus.clear = 1'b0;
      model_clear();
      check("abort_busy", 32'(bus.busy), 32'd0);
      count_done(14, nd);
      check("abort_no_done", 32'(nd), 32'd0);
      chk_flag("abort_flag00", 0, 0, 1'b1);
      chk_flag("abort_flag33", 3, 3, 1'b1);

      // new_pixel while busy is ignored
      run_req(0, 0, 1'b1, 1'b0);
      count_done(14, nd);
      check("inject_no_done", 32'(nd), 32'd0);
      chk_flag("inject_flag22", 2, 2, 1'b1);

      // Pixel write while busy is ignored
      run_req(2, 2, 1'b0, 1'b1);
      run_req(2, 2, 1'b0, 1'b0);
      chk_flag("wrbusy_flag22", 2, 2, 1'b1);

      // Out-of-range centre dropped; out-of-range write ignored
      bus.center_addr = {3'd7, 3'd7};
      bus.new_pixel   = 1'b1;
      @(negedge clk);
      bus.new_pixel = 1'b0;
      check("oor_busy", 32'(bus.busy), 32'd0);
      count_done(14, nd);
      check("oor_no_done", 32'(nd), 32'd0);
      wr(6, 0, 200);
      run_req(5, 0, 1'b0, 1'b0);
      chk_flag("oor_flag50", 5, 0, 1'b1);

      // Reset mid-request clears pixels and flags
      wr(0, 1, 9);
      bus.center_addr = {3'd1, 3'd1};
      bus.new_pixel   = 1'b1;
      @(negedge clk);
      bus.new_pixel = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check("mreset_busy", 32'(bus.busy), 32'd0);
      count_done(12, nd);
      check("mreset_no_done", 32'(nd), 32'd0);
      chk_flag("mreset_flag00", 0, 0, 1'b1);
      run_req(0, 0, 1'b0, 1'b0);
      chk_flag("mreset_px_flag00", 0, 0, 1'b1);

      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/eda_regional_max_core.md
# eda_regional_max_core

Single-window engine for regional-maximum detection (imregionalmax-style) on an M×N greyscale image. It holds the image in an internal pixel RAM and a one-bit-per-pixel "iterated" flag map, where 1 means "still a regional-max candidate". Each `new_pixel` request evaluates the 3×3 window around one centre pixel and may clear that centre's flag. An external sequencer repeats raster sweeps until no `changed` pulse occurs; the flag map is then the regional-maximum mask.

## Interface
Parameters:
- `M`, 6, image rows
- `N`, 6, image columns
- `PIXEL_WIDTH`, 8, bits per pixel
- `WINDOW_WIDTH`, 9, window positions visited per request (3×3)
- `I_WIDTH`, $clog2(M), row index width
- `J_WIDTH`, $clog2(N), column index width
- `ADDR_WIDTH`, I_WIDTH+J_WIDTH, address width; address = {row, col}

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `write_en` in 1: write `pixel_in` to `wr_addr` this edge
- `wr_addr` in ADDR_WIDTH: {i, j} pixel write address
- `pixel_in` in PIXEL_WIDTH: pixel write data
- `center_addr` in ADDR_WIDTH: {i, j} of window centre, sampled with `new_pixel`
- `new_pixel` in 1: one-cycle request to process `center_addr`
- `clear` in 1: set every flag to 1 and abort any request
- `flag_addr` in ADDR_WIDTH: {i, j} flag read address
- `flag_out` out 1: flag at `flag_addr`, combinational read
- `busy` out 1: high while a request is in progress
- `done` out 1: one-cycle pulse when a request completes
- `changed` out 1: valid with `done`; 1 when the centre flag went from 1 to 0

## Operation
- Reset: all pixels are 0, all flags are 1, FSM is IDLE, and `busy`, `done`, `changed` are 0.
- Pixel RAM is M×N registers with synchronous write and combinational read.
  - A write whose row ≥ M or column ≥ N is ignored.
  - Writes are ignored while `busy` is high.
- Flag map is M×N registers. `clear` sets all flags to 1 in one edge.
- FSM states: IDLE → FETCH → UPDATE → IDLE.
- IDLE: when `new_pixel` is high and `clear` is low, latch `center_addr` and go to FETCH.
  - If the centre row ≥ M or column ≥ N, the request is dropped: no `busy`, no `done`.
- FETCH: 9 cycles, one window offset per cycle, row-major from (-1,-1) to (+1,+1).
  - The centre offset and out-of-image offsets (row/col < 0 or ≥ M/N) are skipped but still take their cycle.
  - Kill condition for a valid neighbour q of centre p: pixel(q) > pixel(p), or pixel(q) == pixel(p) and flag(q) == 0.
  - Any kill sets an internal kill bit.
- UPDATE: 1 cycle. If kill is set and flag(p) == 1, clear flag(p) and set `changed`. Go to IDLE and pulse `done`.
- A cleared flag is never set again except by `clear` or `reset`.
- Pixel comparisons are unsigned PIXEL_WIDTH.
- `new_pixel` while `busy` is ignored.
- `clear` has priority: in IDLE it drops a simultaneous `new_pixel`; during FETCH or UPDATE it aborts the request with no `done` and no flag update.
- `reset` mid-operation returns everything to the reset state.

## Timing
- `new_pixel` sampled at edge k: `busy` is high from edge k to edge k+10.
- The FETCH offsets are evaluated at edges k+1…k+9.
- The flag write happens at edge k+10, when `done` and `changed` go high for exactly one cycle.
- A new request is accepted at edge k+11 at the earliest. Throughput is 1 window per 11 cycles.
- `flag_out` reflects a flag write or clear in the cycle after the edge that performed it.
- A pixel write at edge t is visible to a FETCH reading it at edge t+1 or later.

## Configuration
- `EDA_REGIONAL_MAX_CONN8_EN` defined: 8-connectivity; all 8 neighbours are evaluated.
- Undefined: 4-connectivity; the diagonal offsets (±1,±1) are skipped like out-of-image positions. Cycle timing is unchanged (still 9 FETCH cycles).

## Test plan
- Reset, write all 36 pixels = 5, request centre (0,0) → `done` at k+10, `changed`=0, `flag_out`(0,0)=1.
- Pixel (0,1)=9, rest 5, request (0,0) → `changed`=1, flag(0,0)=0; request (0,1) → `changed`=0, flag(0,1)=1.
- Propagation: flag(0,0)=0 with pixels (0,0)=(1,0)=5, (2,0)=4, other neighbours of (1,0) < 5; request (1,0) → `changed`=1 from the equal-and-flagged neighbour.
- Pixel (1,1)=9 only, request (0,0) → flag cleared with CONN8_EN, kept at 1 without it; `done` timing identical in both builds.
- Assert `clear` at k+4 of a killing request → no `done`, all flags 1, `busy` low next cycle; `new_pixel` during `busy` → ignored.
- Request centre (7,7) or write to (6,0) → no `done`, RAM unchanged.
